fft_mag_writer: RTL and testbench
=================================

FFT_MAG_WRITER -- requirements
Module: fft_mag_writer

Interface
REQ-001 SHALL have parameter C_ADDR_WIDTH, default 8, meaning spectrum RAM address width; bins written = 2^C_ADDR_WIDTH.
REQ-002 SHALL have parameter C_DATA_WIDTH, default 8, meaning spectrum RAM word width (bar height).
REQ-003 SHALL have parameter C_IN_WIDTH, default 16, meaning signed width of the FFT real/imag inputs.
REQ-004 SHALL have parameter C_SHIFT, default 7, meaning right-shift applied to the magnitude before saturation.
REQ-005 SHALL have port clk, input, 1, the single clock for all logic.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port freeze, input, 1, which holds the displayed spectrum when high; sampled only in IDLE.
REQ-008 SHALL have port fft_valid, input, 1, which qualifies one FFT bin per cycle.
REQ-009 SHALL have port fft_last, input, 1, which marks the final bin of an FFT frame.
REQ-010 SHALL have port fft_re, input, C_IN_WIDTH, the signed real part of the bin.
REQ-011 SHALL have port fft_im, input, C_IN_WIDTH, the signed imaginary part of the bin.
REQ-012 SHALL have port ram_we, output, 1, the spectrum RAM write enable.
REQ-013 SHALL have port ram_addr, output, C_ADDR_WIDTH, the spectrum RAM write address (bin index).
REQ-014 SHALL have port ram_din, output, C_DATA_WIDTH, the spectrum RAM write data.
REQ-015 SHALL have port frame_done, output, 1, a one-cycle pulse after the last write of a frame.
REQ-016 SHALL have port short_err, output, 1, a sticky flag set when a frame ends before all bins are written.

Function
REQ-017 SHALL implement an FSM with states IDLE, WRITE, SKIP, DONE.
REQ-018 In IDLE with freeze=0 and fft_valid=1: the bin SHALL be accepted as bin 0 and the FSM SHALL enter WRITE; with freeze=1, input SHALL be ignored and the FSM SHALL stay in IDLE.
REQ-019 In WRITE, each fft_valid SHALL increment the bin counter; after bin 2^C_ADDR_WIDTH-1 is accepted, the FSM SHALL go to SKIP, or to DONE if fft_last is coincident.
REQ-020 In SKIP, valid bins SHALL be discarded until fft_valid&fft_last, then the FSM SHALL go to DONE.
REQ-021 In WRITE, fft_valid&fft_last before the final bin SHALL write that bin, set short_err, and go to DONE.
REQ-022 DONE SHALL last one cycle, then return to IDLE; frame_done SHALL pulse once the final pipelined write has issued.
REQ-023 Stage 1 SHALL register |re| and |im|; the most-negative input SHALL saturate to the maximum positive value.
REQ-024 Stage 2 SHALL compute mag = max + (min>>1) at C_IN_WIDTH+1 bits, shift right by C_SHIFT, saturate to 2^C_DATA_WIDTH-1, and register ram_din.
REQ-025 Latency SHALL be 2 cycles: a bin accepted at cycle N SHALL produce ram_we=1 with its address at cycle N+2.
REQ-026 ram_addr SHALL travel in the pipeline alongside its data; fft_valid gaps SHALL produce ram_we=0 gaps without reordering.
REQ-027 ram_we SHALL never assert for discarded (SKIP or frozen) bins.
REQ-028 The block SHALL apply no backpressure; one bin per cycle SHALL be sustained.

Reset
REQ-029 rst SHALL force the FSM to IDLE and clear the bin counter, both pipeline stages, ram_we, ram_addr, ram_din, frame_done and short_err.
REQ-030 rst asserted mid-frame SHALL abandon the frame with no further writes; the next frame SHALL restart at bin 0.

Structure
REQ-031 The FSM state encoding and the saturating-abs width constants SHALL reside in the shared package spectrum_pkg.
REQ-032 The magnitude datapath (stages 1-2) SHALL be one sub-module, fft_mag_approx; the FSM and counter SHALL stay in the top.

Verification
REQ-033 Frame of 512 bins with re=256·k and im=0 for bins k<256 -> 256 writes, addr 0..255, din=min(2k,255), frame_done one cycle after the write to addr 255.
REQ-034 re=-32768, im=-32768 at bin 0 -> din=255 at addr 0 and no sign wrap.
REQ-035 re=1000, im=400 at bin 3 -> mag=1200, din=9 at addr 3 two cycles after acceptance.
REQ-036 fft_last at bin 100 -> writes to addr 0..100 only, short_err=1, frame_done pulses.
REQ-037 freeze=1 during a full frame -> zero writes; freeze dropped mid-frame -> no writes until the next frame starts.
REQ-038 rst asserted at bin 50 -> no writes after reset; the next frame writes from addr 0 and short_err=0.

Source files
------------

// File: rtl/spectrum_pkg.sv
// -----------------------------------------------------------------------------
// spectrum_pkg
// Shared definitions for the FFT magnitude writer:
//   - state_e        : FSM state encoding of fft_mag_writer
//   - MAG_GUARD_BITS : extra bits the magnitude sum needs above the input width
// -----------------------------------------------------------------------------
package spectrum_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_SKIP  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // |x| is saturated to the largest positive value, so it fits the input
    // width; max + (min >> 1) can exceed it and needs one more bit.
    localparam int MAG_GUARD_BITS = 1;

endpackage : spectrum_pkg

// File: rtl/fft_mag_approx.sv
// -----------------------------------------------------------------------------
// fft_mag_approx
// Two-stage magnitude approximation |z| ~= max(|re|,|im|) + min(|re|,|im|)/2,
// scaled down by C_SHIFT and saturated to the RAM word width. The bin address
// and a final-bin tag travel through the pipeline alongside the data.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   in_valid           accepted bin this cycle
//   in_last            accepted bin is the final write of its frame
//   in_addr            bin index of the accepted bin
//   in_re, in_im       signed FFT bin components
//   out_valid          write strobe (two cycles after in_valid)
//   out_last           write carries the final bin of its frame
//   out_addr, out_din  write address and saturated magnitude
// -----------------------------------------------------------------------------
module fft_mag_approx
    import spectrum_pkg::*;
#(
    parameter int C_ADDR_WIDTH = 8,
    parameter int C_DATA_WIDTH = 8,
    parameter int C_IN_WIDTH   = 16,
    parameter int C_SHIFT      = 7
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic                           in_last,
    input  logic        [C_ADDR_WIDTH-1:0] in_addr,
    input  logic signed [C_IN_WIDTH-1:0]   in_re,
    input  logic signed [C_IN_WIDTH-1:0]   in_im,
    output logic                           out_valid,
    output logic                           out_last,
    output logic        [C_ADDR_WIDTH-1:0] out_addr,
    output logic        [C_DATA_WIDTH-1:0] out_din
);

    localparam int MAG_W = C_IN_WIDTH + MAG_GUARD_BITS;
    localparam logic [C_IN_WIDTH-1:0] ABS_MAX = {1'b0, {(C_IN_WIDTH-1){1'b1}}};
    localparam logic [C_IN_WIDTH-1:0] NEG_MIN = {1'b1, {(C_IN_WIDTH-1){1'b0}}};
    localparam logic [MAG_W-1:0]      DIN_MAX = MAG_W'((64'd1 << C_DATA_WIDTH) - 64'd1);

    // Two's-complement negation of the most-negative value wraps back to
    // itself, so that one code is clamped to the largest positive value.
    function automatic logic [C_IN_WIDTH-1:0] sat_abs(input logic [C_IN_WIDTH-1:0] x);
        if (x == NEG_MIN)
            return ABS_MAX;
        else if (x[C_IN_WIDTH-1])
            return C_IN_WIDTH'(-x);
        else
            return x;
    endfunction

    // Stage 1: absolute values
    logic                    s1_valid_q, s1_valid_d;
    logic                    s1_last_q,  s1_last_d;
    logic [C_ADDR_WIDTH-1:0] s1_addr_q,  s1_addr_d;
    logic [C_IN_WIDTH-1:0]   abs_re_q,   abs_re_d;
    logic [C_IN_WIDTH-1:0]   abs_im_q,   abs_im_d;

    // Stage 2: scaled, saturated magnitude
    logic                    s2_valid_q, s2_valid_d;
    logic                    s2_last_q,  s2_last_d;
    logic [C_ADDR_WIDTH-1:0] s2_addr_q,  s2_addr_d;
    logic [C_DATA_WIDTH-1:0] s2_din_q,   s2_din_d;

    logic [C_IN_WIDTH-1:0]   mag_max, mag_min;
    logic [MAG_W-1:0]        mag, mag_shifted;

    always_comb begin
        // NOTE: every signal driven here gets a value on every path before any
        // conditional logic, otherwise synthesis infers a latch.
        s1_valid_d = in_valid;
        s1_last_d  = in_last;
        s1_addr_d  = in_addr;
        abs_re_d   = sat_abs(in_re);
        abs_im_d   = sat_abs(in_im);

        mag_max     = (abs_re_q >= abs_im_q) ? abs_re_q : abs_im_q;
        mag_min     = (abs_re_q >= abs_im_q) ? abs_im_q : abs_re_q;
        mag         = MAG_W'(mag_max) + MAG_W'(mag_min >> 1);
        mag_shifted = mag >> C_SHIFT;

        s2_valid_d = s1_valid_q;
        s2_last_d  = s1_last_q;
        s2_addr_d  = s1_addr_q;
        s2_din_d   = (mag_shifted > DIN_MAX) ? DIN_MAX[C_DATA_WIDTH-1:0]
                                             : mag_shifted[C_DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        // NOTE: data registers are reset along with the strobes so a reset
        // leaves ram_addr/ram_din at zero rather than stale values.
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_addr_q  <= '0;
            abs_re_q   <= '0;
            abs_im_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_addr_q  <= '0;
            s2_din_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_last_q  <= s1_last_d;
            s1_addr_q  <= s1_addr_d;
            abs_re_q   <= abs_re_d;
            abs_im_q   <= abs_im_d;
            s2_valid_q <= s2_valid_d;
            s2_last_q  <= s2_last_d;
            s2_addr_q  <= s2_addr_d;
            s2_din_q   <= s2_din_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_last  = s2_last_q;
    assign out_addr  = s2_addr_q;
    assign out_din   = s2_din_q;

endmodule : fft_mag_approx

// File: rtl/fft_mag_writer.sv
// -----------------------------------------------------------------------------
// fft_mag_writer
// Accepts a stream of FFT bins, writes the first 2^C_ADDR_WIDTH bin
// magnitudes of each frame to a spectrum RAM and discards the rest.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   freeze              hold the displayed spectrum (sampled in IDLE only)
//   fft_valid/fft_last  bin qualifier / final bin of a frame
//   fft_re, fft_im      signed bin components
//   ram_we/addr/din     spectrum RAM write port (2-cycle latency)
//   frame_done          one-cycle pulse the cycle after a frame's last write
//   short_err           sticky: a frame ended before all bins were written
// -----------------------------------------------------------------------------
module fft_mag_writer
    import spectrum_pkg::*;
#(
    parameter int C_ADDR_WIDTH = 8,
    parameter int C_DATA_WIDTH = 8,
    parameter int C_IN_WIDTH   = 16,
    parameter int C_SHIFT      = 7
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           freeze,
    input  logic                           fft_valid,
    input  logic                           fft_last,
    input  logic signed [C_IN_WIDTH-1:0]   fft_re,
    input  logic signed [C_IN_WIDTH-1:0]   fft_im,
    output logic                           ram_we,
    output logic        [C_ADDR_WIDTH-1:0] ram_addr,
    output logic        [C_DATA_WIDTH-1:0] ram_din,
    output logic                           frame_done,
    output logic                           short_err
);

    localparam logic [C_ADDR_WIDTH-1:0] CNT_MAX = '1;

    state_e                  state_q, state_d;
    logic [C_ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                    mid_frame_q, mid_frame_d;
    logic                    short_err_q, short_err_d;
    logic                    frame_done_q, frame_done_d;

    logic                    acc_valid;
    logic                    acc_final;
    logic [C_ADDR_WIDTH-1:0] acc_addr;

    logic                    pipe_valid, pipe_last;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mid_frame_d = mid_frame_q;
        short_err_d = short_err_q;
        acc_valid   = 1'b0;
        acc_final   = 1'b0;
        acc_addr    = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (fft_valid) begin
                    // A frame that was frozen (or cut short by DONE) when it
                    // began is skipped to its end, so an unfrozen mid-frame
                    // bin is never mistaken for bin 0.
                    if (!freeze && !mid_frame_q) begin
                        acc_valid = 1'b1;
                        acc_addr  = '0;
                        cnt_d     = C_ADDR_WIDTH'(1);
                        if (fft_last) begin
                            acc_final   = 1'b1;
                            short_err_d = 1'b1;
                            state_d     = ST_DONE;
                        end else begin
                            state_d = ST_WRITE;
                        end
                    end else begin
                        mid_frame_d = !fft_last;
                    end
                end
            end
            ST_WRITE: begin
                if (fft_valid) begin
                    acc_valid = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == CNT_MAX) begin
                        acc_final = 1'b1;
                        state_d   = fft_last ? ST_DONE : ST_SKIP;
                    end else if (fft_last) begin
                        acc_final   = 1'b1;
                        short_err_d = 1'b1;
                        state_d     = ST_DONE;
                    end
                end
            end
            ST_SKIP: begin
                if (fft_valid && fft_last)
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                if (fft_valid)
                    mid_frame_d = !fft_last;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The final-bin tag reaches the pipeline output with its write, so the
    // pulse lands one cycle after that write whether the FSM is still
    // skipping or has already finished the frame.
    always_comb frame_done_d = pipe_valid && pipe_last;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            mid_frame_q  <= 1'b0;
            short_err_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mid_frame_q  <= mid_frame_d;
            short_err_q  <= short_err_d;
            frame_done_q <= frame_done_d;
        end
    end

    fft_mag_approx #(
        .C_ADDR_WIDTH (C_ADDR_WIDTH),
        .C_DATA_WIDTH (C_DATA_WIDTH),
        .C_IN_WIDTH   (C_IN_WIDTH),
        .C_SHIFT      (C_SHIFT)
    ) u_mag (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (acc_valid),
        .in_last   (acc_final),
        .in_addr   (acc_addr),
        .in_re     (fft_re),
        .in_im     (fft_im),
        .out_valid (pipe_valid),
        .out_last  (pipe_last),
        .out_addr  (ram_addr),
        .out_din   (ram_din)
    );

    assign ram_we     = pipe_valid;
    assign frame_done = frame_done_q;
    assign short_err  = short_err_q;

endmodule : fft_mag_writer

// File: tb/tb_fft_mag_writer.sv
// -----------------------------------------------------------------------------
// tb_fft_mag_writer
// Directed stimulus with a write scoreboard: each bin expected to be written
// pushes {addr, din} when driven; the monitor pops and compares on ram_we.
// -----------------------------------------------------------------------------
module tb_fft_mag_writer;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int IW = 16;
    localparam int SH = 7;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 freeze;
    logic                 fft_valid;
    logic                 fft_last;
    logic signed [IW-1:0] fft_re;
    logic signed [IW-1:0] fft_im;
    logic                 ram_we;
    logic [AW-1:0]        ram_addr;
    logic [DW-1:0]        ram_din;
    logic                 frame_done;
    logic                 short_err;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_writes = 0;
    int   n_fd     = 0;
    int   cyc      = 0;
    int   last_we_cyc = 0;
    int   fd_cyc   = 0;

    fft_mag_writer #(
        .C_ADDR_WIDTH (AW),
        .C_DATA_WIDTH (DW),
        .C_IN_WIDTH   (IW),
        .C_SHIFT      (SH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .freeze     (freeze),
        .fft_valid  (fft_valid),
        .fft_last   (fft_last),
        .fft_re     (fft_re),
        .fft_im     (fft_im),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .frame_done (frame_done),
        .short_err  (short_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Reference magnitude: saturating abs, max + min/2, shift, clamp.
    function automatic int exp_din(input int re, input int im);
        int a, b, mx, mn, m;
        a  = (re < 0) ? -re : re;
        b  = (im < 0) ? -im : im;
        if (a > 32767) a = 32767;
        if (b > 32767) b = 32767;
        mx = (a > b) ? a : b;
        mn = (a > b) ? b : a;
        m  = (mx + mn / 2) / (1 << SH);
        return (m > 255) ? 255 : m;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (ram_we) begin
            n_writes++;
            last_we_cyc = cyc;
            check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("wr_addr", 32'(ram_addr), 32'(e.addr));
                check("wr_din",  32'(ram_din),  32'(e.din));
            end
        end
        if (frame_done) begin
            n_fd++;
            fd_cyc = cyc;
        end
    end

    task automatic drive_bin(input logic signed [IW-1:0] re, input logic signed [IW-1:0] im,
                             input logic last, input bit exp_we, input int addr, input int din);
        fft_valid = 1'b1;
        fft_re    = re;
        fft_im    = im;
        fft_last  = last;
        if (exp_we) sb.push_back('{addr: AW'(addr), din: DW'(din)});
        @(posedge clk); #1;
        fft_valid = 1'b0;
        fft_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        fft_valid = 1'b0;
        fft_last  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic new_phase();
        n_writes = 0;
        n_fd     = 0;
    endtask

    task automatic end_phase(input string tag, input int writes, input int fds);
        idle(6);
        check({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
        check({tag, "_writes"}, 32'(n_writes), 32'(writes));
        check({tag, "_frame_done"}, 32'(n_fd), 32'(fds));
        sb.delete();
    endtask

    initial begin
        logic signed [IW-1:0] r, i;
        rst       = 1'b1;
        freeze    = 1'b0;
        fft_valid = 1'b0;
        fft_last  = 1'b0;
        fft_re    = '0;
        fft_im    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_we",         32'(ram_we),     32'd0);
        check("rst_addr",       32'(ram_addr),   32'd0);
        check("rst_din",        32'(ram_din),    32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_short_err",  32'(short_err),  32'd0);
        rst = 1'b0;
        idle(2);

        // 512-bin frame, re = 256k clamped to the 16-bit range (k >= 128 all
        // saturate to 255 either way), im = 0; the upper half is skipped.
        new_phase();
        for (int k = 0; k < 512; k++) begin
            if (k < 256) begin
                r = (k < 128) ? IW'(256 * k) : 16'sd32767;
                drive_bin(r, '0, 1'b0, 1'b1, k, (2 * k > 255) ? 255 : 2 * k);
            end else begin
                r = IW'($urandom);
                i = IW'($urandom);
                drive_bin(r, i, k == 511, 1'b0, 0, 0);
            end
        end
        end_phase("full512", 256, 1);
        check("full512_fd_timing", 32'(fd_cyc - last_we_cyc), 32'd1);
        check("full512_short_err", 32'(short_err), 32'd0);

        // 256-bin frame ending exactly at the last bin, with valid gaps;
        // bin 0 is most-negative on both axes, bin 3 is (1000, 400).
        new_phase();
        for (int k = 0; k < 256; k++) begin
            if (k == 0) begin
                drive_bin(16'sh8000, 16'sh8000, 1'b0, 1'b1, 0, 255);
            end else if (k == 3) begin
                drive_bin(16'sd1000, 16'sd400, 1'b0, 1'b1, 3, 9);
            end else begin
                r = IW'($urandom);
                i = IW'($urandom);
                drive_bin(r, i, k == 255, 1'b1, k, exp_din(int'(r), int'(i)));
                if (k == 4) begin
                    check("lat_we",   32'(ram_we),   32'd1);
                    check("lat_addr", 32'(ram_addr), 32'd3);
                    check("lat_din",  32'(ram_din),  32'd9);
                end
            end
            if (k % 50 == 25) idle(k % 3 + 1);
        end
        end_phase("exact256", 256, 1);
        check("exact256_short_err", 32'(short_err), 32'd0);

        // Short frame: last at bin 100.
        new_phase();
        for (int k = 0; k <= 100; k++) begin
            r = IW'($urandom);
            i = IW'($urandom);
            drive_bin(r, i, k == 100, 1'b1, k, exp_din(int'(r), int'(i)));
        end
        end_phase("short101", 101, 1);
        check("short101_fd_timing", 32'(fd_cyc - last_we_cyc), 32'd1);
        check("short101_short_err", 32'(short_err), 32'd1);

        // Frozen frame, then freeze dropped mid-frame: nothing written.
        new_phase();
        freeze = 1'b1;
        for (int k = 0; k < 256; k++) drive_bin(IW'($urandom), IW'($urandom), k == 255, 1'b0, 0, 0);
        idle(2);
        for (int k = 0; k < 256; k++) begin
            if (k == 40) freeze = 1'b0;
            drive_bin(IW'($urandom), IW'($urandom), k == 255, 1'b0, 0, 0);
        end
        end_phase("frozen", 0, 0);

        // Next frame after unfreeze starts at bin 0.
        new_phase();
        for (int k = 0; k < 10; k++) begin
            r = IW'($urandom);
            i = IW'($urandom);
            drive_bin(r, i, k == 9, 1'b1, k, exp_din(int'(r), int'(i)));
        end
        end_phase("after_freeze", 10, 1);

        // Reset while bin 50 is presented: bins 0..48 have reached the write
        // port by then, bin 49 is still in stage 1 and is dropped.
        new_phase();
        for (int k = 0; k < 50; k++) begin
            r = IW'($urandom);
            i = IW'($urandom);
            drive_bin(r, i, 1'b0, k <= 48, k, exp_din(int'(r), int'(i)));
        end
        rst = 1'b1;
        drive_bin(IW'($urandom), IW'($urandom), 1'b0, 1'b0, 0, 0);
        idle(1);
        rst = 1'b0;
        check("midrst_we",        32'(ram_we),     32'd0);
        check("midrst_short_err", 32'(short_err),  32'd0);
        check("midrst_fd",        32'(frame_done), 32'd0);
        end_phase("midrst", 49, 0);

        new_phase();
        for (int k = 0; k < 256; k++) begin
            r = IW'($urandom);
            i = IW'($urandom);
            drive_bin(r, i, k == 255, 1'b1, k, exp_din(int'(r), int'(i)));
        end
        end_phase("post_rst", 256, 1);
        check("post_rst_short_err", 32'(short_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_fft_mag_writer
